// File: rtl/dram_bist_seq.sv
// March-style write-then-read BIST sequencer driving one RAM64M (6-bit address, 4-bit data).
// Latency: start sampled at edge 0, done pulses in cycle 130; start is not accepted while busy.
module dram_bist_seq #(
    parameter logic [3:0] SEED  = 4'b0101,
    parameter int         DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       inv,
    output logic [5:0] ram_waddr,
    output logic [5:0] ram_raddr,
    output logic [3:0] ram_di,
    output logic       ram_we,
    input  logic [3:0] ram_do,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_count,
    output logic [5:0] fail_addr
);

    localparam logic [5:0] LAST    = 6'(DEPTH - 1);
    localparam logic [6:0] ERR_MAX = 7'(DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic       inv_l;
    logic       inv_l_nxt;
    logic [5:0] waddr_nxt;
    logic [5:0] raddr_nxt;

    // Read data, expected word and address captured together, compared one cycle later.
    logic       chk_vld;
    logic [3:0] chk_do;
    logic [3:0] chk_exp;
    logic [5:0] chk_addr;
    logic       mism;
    logic [6:0] err_nxt;

    function automatic logic [3:0] exp_word(input logic [5:0] a, input logic iv);
        return a[3:0] ^ SEED ^ {4{iv}};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WRITE;
            WRITE:   if (ram_waddr == LAST) state_nxt = READ;
            READ:    if (ram_raddr == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept    = (state == IDLE) && start;
        inv_l_nxt = accept ? inv : inv_l;
        waddr_nxt = ((state == WRITE) && (state_nxt == WRITE)) ? ram_waddr + 6'd1 : 6'd0;
        raddr_nxt = ((state == READ) && (state_nxt == READ)) ? ram_raddr + 6'd1 : 6'd0;
        mism      = chk_vld && (chk_do != chk_exp);
        err_nxt   = err_count;
        if (accept) begin
            err_nxt = 7'd0;
        end else if (mism && (err_count != ERR_MAX)) begin
            err_nxt = err_count + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_l     <= 1'b0;
            ram_we    <= 1'b0;
            ram_waddr <= 6'd0;
            ram_raddr <= 6'd0;
            ram_di    <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            inv_l     <= inv_l_nxt;
            ram_we    <= (state_nxt == WRITE);
            ram_waddr <= waddr_nxt;
            ram_raddr <= raddr_nxt;
            ram_di    <= (state_nxt == WRITE) ? exp_word(waddr_nxt, inv_l_nxt) : 4'd0;
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_vld  <= 1'b0;
            chk_do   <= 4'd0;
            chk_exp  <= 4'd0;
            chk_addr <= 6'd0;
        end else begin
            chk_vld  <= (state == READ);
            chk_do   <= ram_do;
            chk_exp  <= exp_word(ram_raddr, inv_l);
            chk_addr <= ram_raddr;
        end
    end

    // The last compare lands in DRAIN, so pass is taken from err_nxt rather than err_count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 7'd0;
            fail_addr <= 6'd0;
            pass      <= 1'b0;
        end else begin
            err_count <= err_nxt;
            if (accept) begin
                fail_addr <= 6'd0;
                pass      <= 1'b0;
            end else begin
                if (mism && (err_count == 7'd0)) begin
                    fail_addr <= chk_addr;
                end
                if (state == DRAIN) begin
                    pass <= (err_nxt == 7'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_bist_seq.sv
// Directed bench for dram_bist_seq with a behavioural 64x4 RAM (sync write, async read, optional DOB stuck-at-0).
module tb_dram_bist_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       inv = 1'b0;
    logic [5:0] ram_waddr;
    logic [5:0] ram_raddr;
    logic [3:0] ram_di;
    logic       ram_we;
    logic [3:0] ram_do;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] err_count;
    logic [5:0] fail_addr;

    logic [3:0] mem [64];
    logic       stuck_b = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    int m_done_cyc, m_done_cnt, m_we_cnt, m_we_first, m_we_last;
    int m_busy_cnt, m_busy_last, m_wr_bad;
    logic [5:0] m_r65, m_r66;
    logic [6:0] m_err1;
    logic       m_pass1;

    always #5 clk = ~clk;

    dram_bist_seq #(.SEED(4'b0101), .DEPTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .inv       (inv),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_di    (ram_di),
        .ram_we    (ram_we),
        .ram_do    (ram_do),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_di;
    end

    assign ram_do = mem[ram_raddr] & (stuck_b ? 4'b1101 : 4'b1111);

    // Pulses start, then observes cycles 1..140 (cycle n lies between edges n-1 and n).
    task automatic run_test(input logic inv_v, input int rs_a, input int rs_b);
        logic [3:0] want_di;
        m_done_cyc = -1; m_done_cnt = 0; m_we_cnt = 0; m_we_first = 0; m_we_last = 0;
        m_busy_cnt = 0; m_busy_last = 0; m_wr_bad = 0;
        @(negedge clk);
        start = 1'b1;
        inv   = inv_v;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 140; cyc++) begin
            if (ram_we === 1'b1) begin
                m_we_cnt++;
                if (m_we_first == 0) m_we_first = cyc;
                m_we_last = cyc;
                want_di = 4'(cyc - 1) ^ 4'b0101 ^ {4{inv_v}};
                if (ram_waddr !== 6'(cyc - 1) || ram_di !== want_di) m_wr_bad++;
            end
            if (busy === 1'b1) begin
                m_busy_cnt++;
                m_busy_last = cyc;
            end
            if (done === 1'b1) begin
                m_done_cnt++;
                m_done_cyc = cyc;
            end
            if (cyc == 1) begin
                m_err1  = err_count;
                m_pass1 = pass;
            end
            if (cyc == 65) m_r65 = ram_raddr;
            if (cyc == 66) m_r66 = ram_raddr;
            start = (cyc == rs_a) || (cyc == rs_b);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        inv   = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ram_we, ram_waddr, ram_raddr, ram_di} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_ram got we=%b wa=%0d ra=%0d di=%h want all 0", ram_we, ram_waddr, ram_raddr, ram_di);
        end
        n_checks++;
        if ({busy, done, pass, err_count, fail_addr} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_status got busy=%b done=%b pass=%b err=%0d fa=%0d want all 0", busy, done, pass, err_count, fail_addr);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_clean();
        run_test(1'b0, 0, 0);
        n_checks++;
        if (m_done_cyc !== 130 || m_done_cnt !== 1) begin
            n_fail++;
            $display("FAIL clean_done cycle=%0d pulses=%0d want 130/1", m_done_cyc, m_done_cnt);
        end
        n_checks++;
        if (m_we_cnt !== 64 || m_we_first !== 1 || m_we_last !== 64) begin
            n_fail++;
            $display("FAIL clean_we cnt=%0d first=%0d last=%0d want 64/1/64", m_we_cnt, m_we_first, m_we_last);
        end
        n_checks++;
        if (m_wr_bad !== 0) begin
            n_fail++;
            $display("FAIL clean_wdata bad_writes=%0d want 0", m_wr_bad);
        end
        n_checks++;
        if (m_busy_cnt !== 130 || m_busy_last !== 130) begin
            n_fail++;
            $display("FAIL clean_busy cnt=%0d last=%0d want 130/130", m_busy_cnt, m_busy_last);
        end
        n_checks++;
        if (m_r65 !== 6'd0 || m_r66 !== 6'd1) begin
            n_fail++;
            $display("FAIL clean_raddr c65=%0d c66=%0d want 0/1", m_r65, m_r66);
        end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 7'd0 || fail_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL clean_result pass=%b err=%0d fa=%0d want 1/0/0", pass, err_count, fail_addr);
        end
        n_checks++;
        if (mem[7] !== 4'b0010) begin
            n_fail++;
            $display("FAIL clean_word7 got %b want 0010", mem[7]);
        end
    endtask

    task automatic test_inv();
        run_test(1'b1, 0, 0);
        n_checks++;
        if (mem[7] !== 4'b1101) begin
            n_fail++;
            $display("FAIL inv_word7 got %b want 1101", mem[7]);
        end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 7'd0 || m_wr_bad !== 0) begin
            n_fail++;
            $display("FAIL inv_result pass=%b err=%0d bad_writes=%0d want 1/0/0", pass, err_count, m_wr_bad);
        end
    endtask

    task automatic test_stuck();
        stuck_b = 1'b1;
        run_test(1'b0, 0, 0);
        n_checks++;
        if (err_count !== 7'd32) begin
            n_fail++;
            $display("FAIL stuck_err got %0d want 32", err_count);
        end
        n_checks++;
        if (fail_addr !== 6'd2) begin
            n_fail++;
            $display("FAIL stuck_fail_addr got %0d want 2", fail_addr);
        end
        n_checks++;
        if (pass !== 1'b0 || m_done_cyc !== 130) begin
            n_fail++;
            $display("FAIL stuck_pass pass=%b done_cycle=%0d want 0/130", pass, m_done_cyc);
        end
        stuck_b = 1'b0;
    endtask

    task automatic test_restart();
        run_test(1'b0, 10, 130);
        n_checks++;
        if (m_done_cnt !== 1 || m_done_cyc !== 130) begin
            n_fail++;
            $display("FAIL restart_done pulses=%0d cycle=%0d want 1/130", m_done_cnt, m_done_cyc);
        end
        n_checks++;
        if (m_we_cnt !== 64 || m_busy_cnt !== 130) begin
            n_fail++;
            $display("FAIL restart_len we=%0d busy=%0d want 64/130", m_we_cnt, m_busy_cnt);
        end
        n_checks++;
        if (pass !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_pass got %b want 1", pass);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (ram_we !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre we got %b want 1", ram_we);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ram_we !== 1'b0 || busy !== 1'b0 || err_count !== 7'd0 || ram_waddr !== 6'd0) begin
            n_fail++;
            $display("FAIL midrst_abort we=%b busy=%b err=%0d wa=%0d want 0/0/0/0", ram_we, busy, err_count, ram_waddr);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle busy=%b we=%b want 0/0", busy, ram_we);
        end
        run_test(1'b0, 0, 0);
        n_checks++;
        if (pass !== 1'b1 || err_count !== 7'd0 || m_done_cyc !== 130) begin
            n_fail++;
            $display("FAIL midrst_rerun pass=%b err=%0d done_cycle=%0d want 1/0/130", pass, err_count, m_done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        stuck_b = 1'b1;
        run_test(1'b0, 0, 0);
        n_checks++;
        if (pass !== 1'b0 || err_count !== 7'd32) begin
            n_fail++;
            $display("FAIL b2b_first pass=%b err=%0d want 0/32", pass, err_count);
        end
        stuck_b = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (err_count !== 7'd32 || fail_addr !== 6'd2 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hold err=%0d fa=%0d pass=%b want 32/2/0", err_count, fail_addr, pass);
        end
        run_test(1'b0, 0, 0);
        n_checks++;
        if (m_err1 !== 7'd0 || m_pass1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_clear err=%0d pass=%b at cycle 1 want 0/0", m_err1, m_pass1);
        end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 7'd0 || fail_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL b2b_second pass=%b err=%0d fa=%0d want 1/0/0", pass, err_count, fail_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 4'd0;
        test_reset();
        test_clean();
        test_inv();
        test_stuck();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
